hazard_ctrl_unit: RTL

//  Parametrised hazard/stall/flush controller for the N-stage MIPS pipeline; successor to the fixed 5-stage hazard unit.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/hz_match_scan.sv | 47 ++++
 rtl/hazard_ctrl_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the hazard controller: register index type,
// hazard FSM state encoding and the forward-select value meaning "regfile".
package cpu_types_pkg;

    localparam int REG_W_DEF = 5;
    localparam int FWD_RF    = 0;

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DWAIT  = 2'd1,
        HZ_SQUASH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hz_match_scan.sv
// Priority scan of the in-flight producer stages for one decode source.
// Reports any match, a match against a load in stage 0, and the forward select.
module hz_match_scan
    import cpu_types_pkg::*;
#(
    parameter int NSTAGES = 2,
    parameter int REG_W   = 5,
    parameter int FSEL_W  = $clog2(NSTAGES + 1)
) (
    input  logic [REG_W-1:0]         src,
    input  logic                     src_used,
    input  logic [NSTAGES*REG_W-1:0] stg_dest,
    input  logic [NSTAGES-1:0]       stg_wen,
    input  logic                     load0,
    output logic                     hit,
    output logic                     load_hit,
    output logic [FSEL_W-1:0]        sel
);

    logic [NSTAGES-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            match[k] = src_used && stg_wen[k]
                       && (stg_dest[k*REG_W +: REG_W] != '0)
                       && (stg_dest[k*REG_W +: REG_W] == src);
        end
    end

    // Walk oldest to youngest so the youngest matching producer wins;
    // a load in stage 0 has no data yet and can never be a forward source.
    always_comb begin
        hit      = |match;
        load_hit = match[0] && load0;
        sel      = FSEL_W'(FWD_RF);
        for (int k = NSTAGES - 1; k >= 1; k--) begin
            if (match[k]) begin
                sel = FSEL_W'(k + 1);
            end
        end
        if (match[0] && !load0) begin
            sel = FSEL_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Parametrised stall/flush/forward controller for the N-stage pipeline.
// Define HAZARD_FORWARDING_EN for operand forwarding; otherwise every RAW dependency stalls.
module hazard_ctrl_unit
    import cpu_types_pkg::*;
#(
    parameter int  NSTAGES = 2,
    parameter int  REG_W   = 5,
    parameter int  CNT_W   = 16,
    localparam int FSEL_W  = $clog2(NSTAGES + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ihit,
    input  logic                     dhit,
    input  logic                     dmem_req,
    input  logic [REG_W-1:0]         dec_rs,
    input  logic [REG_W-1:0]         dec_rt,
    input  logic [1:0]               dec_use,
    input  logic [NSTAGES*REG_W-1:0] stg_dest,
    input  logic [NSTAGES-1:0]       stg_wen,
    input  logic [NSTAGES-1:0]       stg_load,
    input  logic                     br_taken,
    output logic                     pcEN,
    output logic                     fdEN,
    output logic                     dxEN,
    output logic                     xmEN,
    output logic                     mwEN,
    output logic                     fd_flush,
    output logic                     dx_flush,
    output logic [FSEL_W-1:0]        fwd_a,
    output logic [FSEL_W-1:0]        fwd_b,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [1:0]               hz_state
);

    hz_state_t          state, next_state;
    logic               dwait;
    logic               data_hz;
    logic               hit_a, hit_b, load_a, load_b;
    logic [FSEL_W-1:0]  sel_a, sel_b;
    logic [FSEL_W-1:0]  fwd_a_c, fwd_b_c;

    hz_match_scan #(.NSTAGES(NSTAGES), .REG_W(REG_W), .FSEL_W(FSEL_W)) u_scan_rs (
        .src      (dec_rs),
        .src_used (dec_use[0]),
        .stg_dest (stg_dest),
        .stg_wen  (stg_wen),
        .load0    (stg_load[0]),
        .hit      (hit_a),
        .load_hit (load_a),
        .sel      (sel_a)
    );

    hz_match_scan #(.NSTAGES(NSTAGES), .REG_W(REG_W), .FSEL_W(FSEL_W)) u_scan_rt (
        .src      (dec_rt),
        .src_used (dec_use[1]),
        .stg_dest (stg_dest),
        .stg_wen  (stg_wen),
        .load0    (stg_load[0]),
        .hit      (hit_b),
        .load_hit (load_b),
        .sel      (sel_b)
    );

`ifdef HAZARD_FORWARDING_EN
    logic unused_scan;
    assign unused_scan = hit_a ^ hit_b;
    assign data_hz     = load_a | load_b;
    assign fwd_a_c     = sel_a;
    assign fwd_b_c     = sel_b;
`else
    logic unused_scan;
    assign unused_scan = ^{load_a, load_b, sel_a, sel_b};
    assign data_hz     = hit_a | hit_b;
    assign fwd_a_c     = FSEL_W'(FWD_RF);
    assign fwd_b_c     = FSEL_W'(FWD_RF);
`endif

    assign dwait    = dmem_req && !dhit;
    assign hz_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HZ_RUN;
        end else begin
            state <= next_state;
        end
    end

    // A pending data access freezes everything, so it outranks a branch;
    // SQUASH waits for the stale fetch to return so it can be dropped.
    always_comb begin
        next_state = state;
        pcEN       = 1'b0;
        fdEN       = 1'b0;
        dxEN       = 1'b0;
        xmEN       = 1'b0;
        mwEN       = 1'b0;
        fd_flush   = 1'b0;
        dx_flush   = 1'b0;
        fwd_a      = FSEL_W'(FWD_RF);
        fwd_b      = FSEL_W'(FWD_RF);
        if (RST) begin
            next_state = HZ_RUN;
        end else begin
            fwd_a = fwd_a_c;
            fwd_b = fwd_b_c;
            if (dwait) begin
                next_state = (state == HZ_SQUASH) ? HZ_SQUASH : HZ_DWAIT;
            end else if (state == HZ_SQUASH) begin
                dxEN = 1'b1;
                xmEN = 1'b1;
                mwEN = 1'b1;
                if (br_taken) begin
                    pcEN     = 1'b1;
                    fdEN     = ihit;
                    fd_flush = ihit;
                    dx_flush = 1'b1;
                end else if (ihit) begin
                    pcEN       = 1'b1;
                    fdEN       = 1'b1;
                    fd_flush   = 1'b1;
                    next_state = HZ_RUN;
                end else begin
                    dx_flush = 1'b1;
                end
            end else begin
                next_state = HZ_RUN;
                dxEN       = 1'b1;
                xmEN       = 1'b1;
                mwEN       = 1'b1;
                if (br_taken) begin
                    pcEN     = 1'b1;
                    dx_flush = 1'b1;
                    if (ihit) begin
                        fdEN     = 1'b1;
                        fd_flush = 1'b1;
                    end else begin
                        next_state = HZ_SQUASH;
                    end
                end else if (data_hz || !ihit) begin
                    dx_flush = 1'b1;
                end else begin
                    pcEN = 1'b1;
                    fdEN = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (!pcEN && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
